// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for a classic 5-stage pipeline.
// Resolves load-use hazards between ID and EX, flushes wrong-path
// instructions on a taken branch/jump in EX, and freezes the pipeline
// while a MEM-stage data access waits for its acknowledge. If the wait
// runs past WAIT_TIMEOUT cycles, the core halts until reset.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the saturating
// stall/flush performance counters. When the macro is undefined, both
// counter ports read constant 0 and no counter flops are built.
module hazard_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             n_rst,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_memread_en_i,
    input  logic             ex_wb_en_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_stall_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_stall_o,
    output logic             mem_wb_flush_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // The last un-acknowledged MEM_WAIT cycle before HALT is taken.
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nxt;
    logic        mem_hold;
    logic        load_use;
    logic        rs1_hit;
    logic        rs2_hit;

    // Hazard detection terms, purely combinational from the stage inputs.
    always_comb begin
        mem_hold = mem_req_i & ~mem_ack_i;
        rs1_hit  = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
        rs2_hit  = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
        load_use = ex_memread_en_i & ex_wb_en_i & (ex_rd_addr_i != 5'd0)
                 & (rs1_hit | rs2_hit);
    end

    // State and wait-counter registers; reset returns to RUN at once.
    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            state    <= RUN;
            wait_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state logic and Mealy stall/flush outputs, in priority order:
    // halt/memory freeze, then branch flush, then load-use bubble.
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = 16'd0;
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_flush_o = 1'b0;

        unique case (state)
            RUN: begin
                if (mem_hold) state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                // A dropped request counts as an ack: no hold, back to RUN.
                if (!mem_hold) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt    = HALT;
                    wait_cnt_nxt = wait_cnt;
                end else begin
                    wait_cnt_nxt = (wait_cnt == 16'hFFFF) ? wait_cnt
                                                          : wait_cnt + 16'd1;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // Freeze everything up to EX and bubble WB. No IF/ID or ID/EX flush
        // here: the registers favour flush over stall, and a flush would
        // destroy the held EX instruction.
        if ((state == HALT) || mem_hold) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (ex_branch_taken_i) begin
            // The ID instruction is wrong-path, so any load-use hit is moot.
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
        end else if (load_use) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
        end
    end

    assign halt_o = (state == HALT);

`ifdef HAZARD_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Saturating event counters for stalled-PC cycles and branch flushes.
    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall_o)    stall_cnt <= sat_inc(stall_cnt);
            if (if_id_flush_o) flush_cnt <= sat_inc(flush_cnt);
        end
    end

    assign stall_cycles_o = stall_cnt;
    assign flush_events_o = flush_cnt;
`else
    assign stall_cycles_o = '0;
    assign flush_events_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a queue-based scoreboard:
// the driver pushes the hand-written expected outputs for each vector,
// and a monitor pops and compares them on the falling edge.
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    // Expected output bit order: {pc, if_id_stall, if_id_flush, id_ex_stall,
    //                            id_ex_flush, ex_mem_stall, mem_wb_flush, halt}
    localparam logic [7:0] Z   = 8'b0000_0000;
    localparam logic [7:0] LU  = 8'b1100_1000;
    localparam logic [7:0] BR  = 8'b0010_1000;
    localparam logic [7:0] FRZ = 8'b1101_0110;
    localparam logic [7:0] HLT = 8'b1101_0111;

    typedef struct packed {
        logic [31:0]      idx;
        logic [7:0]       o;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             n_rst = 1'b0;
    logic [4:0]       id_rs1_addr_i = '0;
    logic [4:0]       id_rs2_addr_i = '0;
    logic             id_rs1_used_i = 1'b0;
    logic             id_rs2_used_i = 1'b0;
    logic [4:0]       ex_rd_addr_i = '0;
    logic             ex_memread_en_i = 1'b0;
    logic             ex_wb_en_i = 1'b0;
    logic             ex_branch_taken_i = 1'b0;
    logic             mem_req_i = 1'b0;
    logic             mem_ack_i = 1'b0;
    logic             pc_stall_o;
    logic             if_id_stall_o;
    logic             if_id_flush_o;
    logic             id_ex_stall_o;
    logic             id_ex_flush_o;
    logic             ex_mem_stall_o;
    logic             mem_wb_flush_o;
    logic             halt_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [CNT_W-1:0] flush_events_o;

    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               vec_idx  = 0;
    logic [CNT_W-1:0] m_stall  = '0;
    logic [CNT_W-1:0] m_flush  = '0;

    hazard_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk_i             (clk_i),
        .n_rst             (n_rst),
        .id_rs1_addr_i     (id_rs1_addr_i),
        .id_rs2_addr_i     (id_rs2_addr_i),
        .id_rs1_used_i     (id_rs1_used_i),
        .id_rs2_used_i     (id_rs2_used_i),
        .ex_rd_addr_i      (ex_rd_addr_i),
        .ex_memread_en_i   (ex_memread_en_i),
        .ex_wb_en_i        (ex_wb_en_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .mem_req_i         (mem_req_i),
        .mem_ack_i         (mem_ack_i),
        .pc_stall_o        (pc_stall_o),
        .if_id_stall_o     (if_id_stall_o),
        .if_id_flush_o     (if_id_flush_o),
        .id_ex_stall_o     (id_ex_stall_o),
        .id_ex_flush_o     (id_ex_flush_o),
        .ex_mem_stall_o    (ex_mem_stall_o),
        .mem_wb_flush_o    (mem_wb_flush_o),
        .halt_o            (halt_o),
        .stall_cycles_o    (stall_cycles_o),
        .flush_events_o    (flush_events_o)
    );

    always #5 clk_i = ~clk_i;

    // Apply one vector just after a rising edge, queue its expectation, and
    // advance the counter model across the following edge.
    task automatic apply(input logic rst_n, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic wb, input logic br,
                         input logic req, input logic ack, input logic [7:0] exp_o);
        exp_t e;
        n_rst = rst_n;
        id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
        id_rs1_used_i = u1;  id_rs2_used_i = u2;
        ex_rd_addr_i = rd;   ex_memread_en_i = mr; ex_wb_en_i = wb;
        ex_branch_taken_i = br; mem_req_i = req; mem_ack_i = ack;
        if (!rst_n) begin
            m_stall = '0;
            m_flush = '0;
        end
        e.idx = 32'(vec_idx);
        e.o   = exp_o;
`ifdef HAZARD_PERF_CNT_EN
        e.sc  = m_stall;
        e.fc  = m_flush;
`else
        e.sc  = '0;
        e.fc  = '0;
`endif
        sb_q.push_back(e);
        vec_idx++;
        @(posedge clk_i);
        if (rst_n) begin
            m_stall = m_stall + CNT_W'(exp_o[7]);
            m_flush = m_flush + CNT_W'(exp_o[5]);
        end
        #1;
    endtask

    // Monitor: one queued expectation per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        logic [7:0] got;
        forever begin
            @(negedge clk_i);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
                       id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, halt_o};
                n_checks++;
                if (got === e.o) n_pass++;
                else $display("FAIL outputs vec %0d: got %b want %b", e.idx, got, e.o);
                n_checks++;
                if (stall_cycles_o === e.sc) n_pass++;
                else $display("FAIL stall_cycles vec %0d: got %0d want %0d", e.idx, stall_cycles_o, e.sc);
                n_checks++;
                if (flush_events_o === e.fc) n_pass++;
                else $display("FAIL flush_events vec %0d: got %0d want %0d", e.idx, flush_events_o, e.fc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached with %0d vectors queued", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk_i); #1;
        //     rst  rs1   rs2   u1 u2 rd    mr wb br rq ak exp
        apply(1'b0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, Z);    // reset state
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, Z);    // idle
        apply(1'b1, 5'd5, 5'd1, 1, 0, 5'd5, 1, 1, 0, 0, 0, LU);   // load-use rs1
        apply(1'b1, 5'd5, 5'd1, 1, 0, 5'd5, 0, 1, 0, 0, 0, Z);    // EX no longer a load
        apply(1'b1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0, Z);    // rd = x0
        apply(1'b1, 5'd2, 5'd7, 1, 1, 5'd7, 1, 1, 0, 0, 0, LU);   // load-use rs2
        apply(1'b1, 5'd2, 5'd7, 1, 0, 5'd7, 1, 1, 0, 0, 0, Z);    // rs2 not read
        apply(1'b1, 5'd7, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0, 0, Z);    // load without writeback
        apply(1'b1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0, 0, BR);   // branch beats load-use
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, BR);   // plain branch
        // memory wait: 3 un-acked cycles, hazards suppressed, release on ack
        apply(1'b1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 1, 0, FRZ);
        apply(1'b1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 1, 0, FRZ);
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, FRZ);
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, Z);    // ack releases
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, Z);
        // request withdrawn in MEM_WAIT acts as an ack
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, FRZ);
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, BR);
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, Z);
        // timeout: entry cycle plus 4 MEM_WAIT cycles, then HALT
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, FRZ);
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, FRZ);
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, FRZ);
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, FRZ);
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, FRZ);  // 4th wait cycle, halt_o still 0
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, HLT);
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, HLT);  // late ack ignored
        apply(1'b1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0, 0, HLT);  // branch/load-use ignored
        // asynchronous reset in HALT
        apply(1'b0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, Z);
        apply(1'b0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0, LU);   // RUN rules during reset
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, Z);
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, BR);
        apply(1'b1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, Z);
        // drain: every queued expectation must have been consumed
        @(posedge clk_i); @(posedge clk_i);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
